uart_rx_param: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 receiver. Adds configurable baud divisor, data width, parity and stop bits, a 2-FF input synchroniser and mid-bit start validation. Delivers frames on a valid/ready output with parity, framing and overrun status. Sits between the board RX pin and the command/packet parser.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_param_if.sv | 28 ++
 rtl/uart_baud_tick.sv | 39 +++
 rtl/uart_rx_param.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared types, parity modes and width helper for the UART blocks
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Minimum width of 1 so a degenerate value still yields a legal vector.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return (width < 1) ? 1 : width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_param_if.sv
// ============================================================================
// uart_rx_param_if : received-frame valid/ready channel with error status
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_perr;
  logic                 rx_ferr;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, rx_perr, rx_ferr, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, rx_perr, rx_ferr, overrun,
    output rx_ready
  );
endinterface

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// uart_baud_tick : free-running 0..CLKS_PER_BIT-1 bit timer with clear
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = clog2(CLKS_PER_BIT)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear,
  output logic [CNT_W-1:0]      count,
  output logic                  tick
);

  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign tick  = (count_q == TERMINAL);
  assign count = count_q;

  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || tick) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_param.sv
// ============================================================================
// uart_rx_param : parametrised UART receiver, valid/ready output with status
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        rxd,
  uart_rx_param_if.master  rx_if
);

  localparam int CNT_W     = clog2(CLKS_PER_BIT);
  localparam int BIT_CNT_W = clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0]     HALF_TERM = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);
  localparam logic                 ODD_PAR   = (PARITY == PAR_ODD);

  logic [1:0]           sync_q, sync_d;
  logic                 rxd_s;
  rx_state_e            state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 overrun_q, overrun_d;
  logic                 timer_clear, tick, commit, accept;
  logic [CNT_W-1:0]     timer_count;

  assign sync_d = {sync_q[0], rxd};
  assign rxd_s  = sync_q[1];

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .count (timer_count),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    timer_clear = 1'b0;
    commit      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_clear = 1'b1;
        bit_cnt_d   = '0;
        if (!rxd_s) begin
          state_d = ST_START;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        // Re-check the line at mid start bit; a short low pulse is a glitch.
        if (timer_count == HALF_TERM) begin
          if (rxd_s) begin
            state_d = ST_IDLE;
          end else begin
            timer_clear = 1'b1;
            state_d     = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          perr_d  = (((^shift_q) ^ rxd_s) != ODD_PAR);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          ferr_d    = ferr_q | ~rxd_s;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_STOP) begin
            commit    = 1'b1;
            bit_cnt_d = '0;
            state_d   = ferr_d ? ST_WAIT_HIGH : ST_IDLE;
          end
        end
      end
      ST_WAIT_HIGH: begin
        timer_clear = 1'b1;
        if (rxd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A commit may coincide with the consumer draining the held frame.
  always_comb begin
    accept     = valid_q & rx_if.rx_ready;
    data_d     = data_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    valid_d    = valid_q & ~accept;
    overrun_d  = 1'b0;
    if (commit) begin
      if (!valid_q || accept) begin
        data_d     = shift_q;
        perr_out_d = perr_q;
        ferr_out_d = ferr_d;
        valid_d    = 1'b1;
      end else begin
        overrun_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= 2'b11;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
  assign rx_if.rx_perr  = perr_out_q;
  assign rx_if.rx_ferr  = ferr_out_q;
  assign rx_if.overrun  = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_param.sv
// ============================================================================
// tb_uart_rx_param : four receiver configurations against a frame-level model
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_param;

  localparam int CPB = 16;
  localparam int DB  [4] = '{8, 7, 9, 6};
  localparam int PAR [4] = '{0, 1, 0, 2};
  localparam int STB [4] = '{1, 1, 2, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd   [4];
  logic ready [4];

  logic       mon_valid [4];
  logic [8:0] mon_data  [4];
  logic       mon_perr  [4];
  logic       mon_ferr  [4];
  logic       mon_ovr   [4];

  int         acc_cnt   [4];
  int         ovr_cnt   [4];
  int         rise_cyc  [4];
  logic       prev_valid[4];
  logic [8:0] last_data [4];
  logic       last_perr [4];
  logic       last_ferr [4];
  int         cyc = 0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_rx_param_if #(.DATA_BITS(DB[g])) rx_if ();

    uart_rx_param #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (DB[g]),
      .PARITY       (PAR[g]),
      .STOP_BITS    (STB[g])
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .rxd   (rxd[g]),
      .rx_if (rx_if.master)
    );

    assign rx_if.rx_ready = ready[g];
    assign mon_valid[g]   = rx_if.rx_valid;
    assign mon_data[g]    = 9'(rx_if.rx_data);
    assign mon_perr[g]    = rx_if.rx_perr;
    assign mon_ferr[g]    = rx_if.rx_ferr;
    assign mon_ovr[g]     = rx_if.overrun;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Transfers and overrun pulses, observed mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mon_valid[i] === 1'b1 && ready[i]) begin
        acc_cnt[i]   = acc_cnt[i] + 1;
        last_data[i] = mon_data[i];
        last_perr[i] = mon_perr[i];
        last_ferr[i] = mon_ferr[i];
      end
      if (mon_ovr[i] === 1'b1) ovr_cnt[i] = ovr_cnt[i] + 1;
      if (mon_valid[i] === 1'b1 && prev_valid[i] !== 1'b1) rise_cyc[i] = cyc;
      prev_valid[i] = mon_valid[i];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model_data(input int i, input logic [8:0] d);
    return d & 9'((1 << DB[i]) - 1);
  endfunction

  // Even parity: total ones over data+parity must be even; odd: must be odd.
  function automatic logic model_perr(input int i, input logic [8:0] d, input logic pb);
    int ones;
    ones = $countones(model_data(i, d)) + int'(pb);
    if (PAR[i] == 0) return 1'b0;
    if (PAR[i] == 1) return (ones % 2) != 0;
    return (ones % 2) == 0;
  endfunction

  function automatic logic model_ferr(input int i, input logic [1:0] stops);
    return !stops[0] || (STB[i] == 2 && !stops[1]);
  endfunction

  function automatic int model_latency(input int i);
    return 2 + CPB / 2 + (DB[i] + ((PAR[i] != 0) ? 1 : 0) + STB[i]) * CPB + 1;
  endfunction

  task automatic bit_out(input int i, input logic v);
    rxd[i] = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input int i, input logic [8:0] d, input logic pb, input logic [1:0] stops);
    bit_out(i, 1'b0);
    for (int b = 0; b < DB[i]; b++) bit_out(i, d[b]);
    if (PAR[i] != 0) bit_out(i, pb);
    for (int s = 0; s < STB[i]; s++) bit_out(i, stops[s]);
  endtask

  task automatic wait_acc(input string tag, input int i, input int prev);
    int n;
    n = 0;
    while (acc_cnt[i] == prev && n < 4 * CPB) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq({tag, "_arrived"}, 32'(acc_cnt[i] != prev), 32'd1);
  endtask

  task automatic send_and_check(input string tag, input int i, input logic [8:0] d,
                                input logic pb, input logic [1:0] stops, input bit chk_lat);
    int prev, t0, lat, exp_lat;
    prev = acc_cnt[i];
    t0   = cyc;
    send_frame(i, d, pb, stops);
    wait_acc(tag, i, prev);
    check_eq({tag, "_data"}, 32'(last_data[i]), 32'(model_data(i, d)));
    check_eq({tag, "_perr"}, 32'(last_perr[i]), 32'(model_perr(i, d, pb)));
    check_eq({tag, "_ferr"}, 32'(last_ferr[i]), 32'(model_ferr(i, stops)));
    if (chk_lat) begin
      lat     = rise_cyc[i] - t0;
      exp_lat = model_latency(i);
      check_eq({tag, "_latency"},
               32'((lat >= exp_lat - 1 && lat <= exp_lat + 1) ? exp_lat : lat), 32'(exp_lat));
    end
    bit_out(i, 1'b1);
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, ovr0, idx;
    logic [8:0] rd;
    logic [1:0] rs;
    for (int i = 0; i < 4; i++) begin
      rxd[i]   = 1'b1;
      ready[i] = 1'b1;
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_eq("rst_valid", 32'(mon_valid[i]), 32'd0);
      check_eq("rst_flags", 32'({mon_perr[i], mon_ferr[i], mon_ovr[i]}), 32'd0);
    end
    check_eq("rst_data", 32'(mon_data[0]), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    send_and_check("8n1_a5", 0, 9'h0A5, 1'b0, 2'b11, 1'b1);

    send_and_check("7e1_good", 1, 9'h035, 1'b0, 2'b11, 1'b1);
    send_and_check("7e1_bad",  1, 9'h035, 1'b1, 2'b11, 1'b0);

    // Break: zero data, zero stop, line held low for 40 bit times.
    prev = acc_cnt[0];
    send_frame(0, 9'h000, 1'b0, 2'b00);
    repeat (40) bit_out(0, 1'b0);
    check_eq("brk_count", 32'(acc_cnt[0] - prev), 32'd1);
    check_eq("brk_ferr",  32'(last_ferr[0]), 32'd1);
    check_eq("brk_data",  32'(last_data[0]), 32'd0);
    bit_out(0, 1'b1);
    bit_out(0, 1'b1);
    send_and_check("brk_next_5a", 0, 9'h05A, 1'b0, 2'b11, 1'b0);

    // Overrun: consumer stalled across two back-to-back frames.
    @(posedge clk); #1 ready[0] = 1'b0;
    @(negedge clk);
    prev = acc_cnt[0];
    ovr0 = ovr_cnt[0];
    send_frame(0, 9'h011, 1'b0, 2'b11);
    send_frame(0, 9'h022, 1'b0, 2'b11);
    bit_out(0, 1'b1);
    check_eq("ovr_pulses", 32'(ovr_cnt[0] - ovr0), 32'd1);
    check_eq("ovr_held_valid", 32'(mon_valid[0]), 32'd1);
    check_eq("ovr_held_data", 32'(mon_data[0]), 32'h11);
    check_eq("ovr_no_accept", 32'(acc_cnt[0] - prev), 32'd0);
    @(posedge clk); #1 ready[0] = 1'b1;
    wait_acc("ovr_drain", 0, prev);
    check_eq("ovr_drain_data", 32'(last_data[0]), 32'h11);
    @(negedge clk); #1;
    check_eq("ovr_valid_drop", 32'(mon_valid[0]), 32'd0);

    // Glitch shorter than half a bit.
    prev = acc_cnt[0];
    rxd[0] = 1'b0;
    repeat (5) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_eq("glitch_no_frame", 32'(acc_cnt[0] - prev), 32'd0);
    check_eq("glitch_valid", 32'(mon_valid[0]), 32'd0);
    send_and_check("glitch_next_c3", 0, 9'h0C3, 1'b0, 2'b11, 1'b0);

    // Reset in the middle of the data bits of 0xFF.
    prev = acc_cnt[0];
    bit_out(0, 1'b0);
    repeat (3) bit_out(0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_data", 32'(mon_data[0]), 32'd0);
    check_eq("midrst_valid", 32'(mon_valid[0]), 32'd0);
    rst = 1'b0;
    rxd[0] = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check_eq("midrst_no_frame", 32'(acc_cnt[0] - prev), 32'd0);
    send_and_check("midrst_next_81", 0, 9'h081, 1'b0, 2'b11, 1'b0);

    send_and_check("9n2_1ff", 2, 9'h1FF, 1'b0, 2'b11, 1'b1);
    send_and_check("9n2_stop2_bad", 2, 9'h0AB, 1'b0, 2'b01, 1'b0);
    send_and_check("6o1_good", 3, 9'h02C, 1'b0, 2'b11, 1'b1);

    for (int k = 0; k < 12; k++) begin
      idx = int'($urandom_range(0, 3));
      rd  = 9'($urandom);
      rs  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      send_and_check("rand", idx, rd, 1'($urandom_range(0, 1)), rs, 1'b0);
      bit_out(idx, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
